// File: rtl/draw_cmd_scheduler_if.sv
// Command and drawing-datapath bundle for draw_cmd_scheduler.
// master drives commands and done; slave is the scheduler.
interface draw_cmd_scheduler_if;
  logic       iCmdValid;
  logic       iCmdClear;
  logic [7:0] iCmdX;
  logic [6:0] iCmdY;
  logic [2:0] iCmdColour;
  logic       oCmdReady;
  logic       oStartBox;
  logic       oStartClear;
  logic [7:0] oBoxX;
  logic [6:0] oBoxY;
  logic [2:0] oBoxColour;
  logic       iDrawDone;
  logic       oBusy;
  logic [3:0] oPending;
  logic       oOverflow;
  logic       oTimeout;

  modport master (
    output iCmdValid, iCmdClear, iCmdX, iCmdY, iCmdColour,
    output iDrawDone,
    input  oCmdReady, oStartBox, oStartClear,
    input  oBoxX, oBoxY, oBoxColour,
    input  oBusy, oPending, oOverflow, oTimeout
  );

  modport slave (
    input  iCmdValid, iCmdClear, iCmdX, iCmdY, iCmdColour,
    input  iDrawDone,
    output oCmdReady, oStartBox, oStartClear,
    output oBoxX, oBoxY, oBoxColour,
    output oBusy, oPending, oOverflow, oTimeout
  );
endinterface

// File: rtl/draw_cmd_scheduler.sv
// Queues box/clear draw commands in a small FIFO and issues them
// one at a time to the drawing datapath, with done/timeout tracking.
module draw_cmd_scheduler #(
  parameter int          DEPTH   = 4,
  parameter logic [15:0] TIMEOUT = 16'd20000
) (
  input logic               iClock,
  input logic               iReset,
  draw_cmd_scheduler_if.slave bus
);

  typedef struct packed {
    logic       clr;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] FULL = 4'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    count;
  state_t        state;
  logic [15:0]   timer;
  cmd_t          head;
  logic          ready;
  logic          push;
  logic          pop;

  logic          start_box;
  logic          start_clear;
  logic [7:0]    box_x;
  logic [6:0]    box_y;
  logic [2:0]    box_col;
  logic          busy;
  logic          overflow;
  logic          timeout;

  assign head  = mem[rd_ptr];
  assign ready = (count < FULL) && !iReset;
  assign push  = bus.iCmdValid && ready;
  assign pop   = (state == IDLE) && (count != 4'd0);

  always_ff @(posedge iClock) begin
    if (push) begin
      mem[wr_ptr] <= '{clr: bus.iCmdClear,
                       x:   bus.iCmdX,
                       y:   bus.iCmdY,
                       col: bus.iCmdColour};
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= 4'd0;
      state       <= IDLE;
      timer       <= 16'd0;
      start_box   <= 1'b0;
      start_clear <= 1'b0;
      box_x       <= 8'd0;
      box_y       <= 7'd0;
      box_col     <= 3'd0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      start_box   <= 1'b0;
      start_clear <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (bus.iCmdValid && !ready) overflow <= 1'b1;

      unique case (state)
        IDLE: begin
          if (pop) begin
            box_x       <= head.x;
            box_y       <= head.y;
            box_col     <= head.col;
            start_box   <= !head.clr;
            start_clear <= head.clr;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= 16'd0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // done has priority over a coinciding timeout
          if (bus.iDrawDone) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (timer == TIMEOUT - 16'd1) begin
            busy    <= 1'b0;
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.oCmdReady   = ready;
  assign bus.oStartBox   = start_box;
  assign bus.oStartClear = start_clear;
  assign bus.oBoxX       = box_x;
  assign bus.oBoxY       = box_y;
  assign bus.oBoxColour  = box_col;
  assign bus.oBusy       = busy;
  assign bus.oPending    = count;
  assign bus.oOverflow   = overflow;
  assign bus.oTimeout    = timeout;

endmodule

// File: doc/draw_cmd_scheduler.md
DRAW_CMD_SCHEDULER -- requirements
Module: draw_cmd_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the command FIFO depth in entries (power of two, 2..8).
REQ-002 Parameter TIMEOUT, default 16'd20000, SHALL set the maximum number of WAIT_DONE cycles before an abort.
REQ-003 Port iClock, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port iReset, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port iCmdValid, input, 1, SHALL indicate that a command is offered this cycle.
REQ-006 Port iCmdClear, input, 1, SHALL select the command type: 1 = clear screen, 0 = box.
REQ-007 Ports iCmdX (input, 8), iCmdY (input, 7) and iCmdColour (input, 3) SHALL carry the box origin and colour, which are ignored for clear commands.
REQ-008 Port oCmdReady, output, 1, SHALL indicate that the FIFO can accept a command.
REQ-009 Ports oStartBox and oStartClear, outputs, 1 each, SHALL be one-cycle start pulses to the drawing datapath.
REQ-010 Ports oBoxX (output, 8), oBoxY (output, 7) and oBoxColour (output, 3) SHALL present the operands of the command in flight.
REQ-011 Port iDrawDone, input, 1, SHALL be the drawing datapath's completion indication.
REQ-012 Ports oBusy (output, 1) and oPending (output, 4) SHALL report a command in flight and the FIFO occupancy.
REQ-013 Ports oOverflow and oTimeout, outputs, 1 each, SHALL be sticky error flags.

Function
REQ-014 A push SHALL occur on a rising edge where iCmdValid=1 and oCmdReady=1, writing {iCmdClear, iCmdX, iCmdY, iCmdColour} at the FIFO tail.
REQ-015 oCmdReady SHALL be combinationally equal to (count < DEPTH) AND NOT iReset.
REQ-016 If iCmdValid=1 while oCmdReady=0 with iReset=0, the command SHALL be dropped and oOverflow SHALL set and remain 1 until reset.
REQ-017 FIFO order SHALL be strictly first-in first-out; pointers SHALL wrap modulo DEPTH, and count SHALL range 0..DEPTH.
REQ-018 A simultaneous push and pop SHALL both take effect with count unchanged, including at count=DEPTH (ready=0 blocks the push) and at count=0 (pop requires count>0, so no pop).
REQ-019 The FSM SHALL have three states: IDLE, ISSUE and WAIT_DONE.
REQ-020 In IDLE with count>0, the next edge SHALL pop the head into oBoxX/oBoxY/oBoxColour and an internal type bit, and move to ISSUE.
REQ-021 In IDLE with count=0, the FSM SHALL remain in IDLE.
REQ-022 ISSUE SHALL last exactly one cycle: oStartBox=1 if type=box, else oStartClear=1; next state WAIT_DONE with timer=0.
REQ-023 In WAIT_DONE, iDrawDone=1 SHALL cause a move to IDLE on the next edge.
REQ-024 In WAIT_DONE without done, the timer SHALL increment; when timer==TIMEOUT-1 the FSM SHALL move to IDLE and set oTimeout (sticky).
REQ-025 iDrawDone SHALL be ignored in IDLE and ISSUE.
REQ-026 If iDrawDone and the timeout coincide, done SHALL win and oTimeout SHALL NOT set.
REQ-027 Latency SHALL be as follows: a push into an empty FIFO with the FSM in IDLE at edge k gives pop at edge k+1, start pulse high during cycle k+1→k+2, and WAIT_DONE from edge k+2.
REQ-028 Back-to-back throughput SHALL be as follows: done sampled at edge n gives IDLE at n, pop at n+1, and the next start pulse in cycle n+1→n+2.
REQ-029 oBoxX/oBoxY/oBoxColour SHALL change only on a pop and SHALL hold stable throughout ISSUE and WAIT_DONE.
REQ-030 oBusy SHALL be 1 in ISSUE and WAIT_DONE and 0 in IDLE; oPending SHALL equal count.
REQ-031 oStartBox and oStartClear SHALL never be high simultaneously and SHALL never be high for two consecutive cycles.

Reset
REQ-032 With iReset=1 at an edge, the block SHALL enter IDLE, empty the FIFO (pointers and count 0), clear the timer, and clear oOverflow/oTimeout.
REQ-033 The reset values of oBoxX/oBoxY/oBoxColour SHALL be 0.
REQ-034 oStartBox, oStartClear, oBusy and oPending SHALL be 0 in the cycle after the reset edge.
REQ-035 Pushes offered while iReset=1 SHALL be ignored and SHALL NOT set oOverflow.
REQ-036 A reset during ISSUE or WAIT_DONE SHALL abandon the command in flight; no start pulse SHALL be reissued and a later iDrawDone SHALL be ignored.

Verification
REQ-037 Single box: push {box, X=10, Y=20, col=5} into an empty FIFO at edge k -> oStartBox=1 for exactly cycle k+1, oBoxX=10, oBoxY=20, oBoxColour=5, oBusy=1; iDrawDone at edge k+6 -> oBusy=0 after that edge.
REQ-038 Fill/overflow: with iDrawDone held 0, push 6 commands -> 1 issued, 4 queued with oPending=4 and oCmdReady=0, the 6th dropped and oOverflow=1; issue order matches push order.
REQ-039 Simultaneous push and pop: push at the same edge as an IDLE pop with count=2 -> count stays 2, and the pushed entry is issued last.
REQ-040 Timeout: set TIMEOUT=8, issue a clear, never assert done -> oStartClear pulse, then IDLE after 8 WAIT_DONE cycles with oTimeout=1; the next queued command issues normally.
REQ-041 Reset mid-operation: assert iReset in WAIT_DONE with count=3 -> oPending=0, oBusy=0, no start pulse, flags 0; iDrawDone afterwards produces no effect.
